// File: rtl/pc_sequencer.sv
// Fetch PC owner: resolves ID redirects (J/JR/CALL/RET) and EX branch redirects,
// with a circular return-address stack and per-stage kill generation.
module pc_sequencer #(
    parameter int unsigned    PC_W      = 16,
    parameter int unsigned    RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            id_valid,
    input  logic [PC_W-1:0] id_pc,
    input  logic            J,
    input  logic            JR,
    input  logic            CALL,
    input  logic            RET,
    input  logic [PC_W-1:0] jmp_target,
    input  logic [PC_W-1:0] jr_target,
    input  logic            ex_br,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      pcSrc,
    output logic            kill_if,
    output logic            kill_id,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] SRC_SEQ  = 3'b000;
    localparam logic [2:0] SRC_JMP  = 3'b001;
    localparam logic [2:0] SRC_JR   = 3'b010;
    localparam logic [2:0] SRC_RET  = 3'b011;
    localparam logic [2:0] SRC_BR   = 3'b100;
    localparam logic [2:0] SRC_HOLD = 3'b101;

    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_m1;
    logic [PC_W-1:0]  pc_next;
    logic             push;
    logic             pop;

    assign top_m1    = top - PTR_W'(1);
    assign ras_empty = (count == CNT_W'(0));
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));

    // Redirect priority: EX taken branch > stall > RET > JR > CALL > J > sequential
    always_comb begin
        pc_next       = pc + PC_W'(1);
        pcSrc         = SRC_SEQ;
        kill_if       = 1'b0;
        kill_id       = 1'b0;
        ras_underflow = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        if (ex_br && ex_taken) begin
            pc_next = ex_target;
            pcSrc   = SRC_BR;
            kill_if = 1'b1;
            kill_id = 1'b1;
        end else if (stall) begin
            pc_next = pc;
            pcSrc   = SRC_HOLD;
        end else if (id_valid && RET) begin
            pcSrc   = SRC_RET;
            kill_if = 1'b1;
            if (ras_empty) begin
                pc_next       = jr_target;
                ras_underflow = 1'b1;
            end else begin
                pc_next = ras[top_m1];
                pop     = 1'b1;
            end
        end else if (id_valid && JR) begin
            pc_next = jr_target;
            pcSrc   = SRC_JR;
            kill_if = 1'b1;
        end else if (id_valid && CALL) begin
            pc_next = jmp_target;
            pcSrc   = SRC_JMP;
            kill_if = 1'b1;
            push    = 1'b1;
        end else if (id_valid && J) begin
            pc_next = jmp_target;
            pcSrc   = SRC_JMP;
            kill_if = 1'b1;
        end
        // Combinational outputs read as zero while reset is held
        if (!rst_n) begin
            pcSrc         = SRC_SEQ;
            kill_if       = 1'b0;
            kill_id       = 1'b0;
            ras_underflow = 1'b0;
        end
    end

    // PC register and RAS; a push when full overwrites the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            top   <= '0;
            count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras[i] <= '0;
            end
        end else begin
            pc <= pc_next;
            if (push) begin
                ras[top] <= id_pc + PC_W'(1);
                top      <= top + PTR_W'(1);
                if (!ras_full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                top   <= top_m1;
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wrap, RAS nesting/overflow/underflow,
// redirect priority and stall hold.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic [15:0] id_pc;
    logic        J;
    logic        JR;
    logic        CALL;
    logic        RET;
    logic [15:0] jmp_target;
    logic [15:0] jr_target;
    logic        ex_br;
    logic        ex_taken;
    logic [15:0] ex_target;
    logic [15:0] pc;
    logic [2:0]  pcSrc;
    logic        kill_if;
    logic        kill_id;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .J            (J),
        .JR           (JR),
        .CALL         (CALL),
        .RET          (RET),
        .jmp_target   (jmp_target),
        .jr_target    (jr_target),
        .ex_br        (ex_br),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .pc           (pc),
        .pcSrc        (pcSrc),
        .kill_if      (kill_if),
        .kill_id      (kill_id),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        stall = 0; id_valid = 0; id_pc = '0; J = 0; JR = 0; CALL = 0; RET = 0;
        jmp_target = '0; jr_target = '0; ex_br = 0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", ras_full); end
        n_cmp++; if ({pcSrc, kill_if, kill_id, ras_underflow} !== 6'b0) begin n_err++; $display("FAIL reset_outs: got %b want 000000", {pcSrc, kill_if, kill_id, ras_underflow}); end
        rst_n = 1;
        tick(); n_cmp++; if (pc !== 16'h0001) begin n_err++; $display("FAIL seq1: got %h want 0001", pc); end
        tick(); n_cmp++; if (pc !== 16'h0002) begin n_err++; $display("FAIL seq2: got %h want 0002", pc); end
        id_valid = 1; J = 1; jmp_target = 16'h0042; #1;
        n_cmp++; if (pcSrc !== 3'b001 || kill_if !== 1'b1 || kill_id !== 1'b0) begin n_err++; $display("FAIL j_ctrl: got %b%b%b want 00110", pcSrc, kill_if, kill_id); end
        tick(); clr();
        n_cmp++; if (pc !== 16'h0042) begin n_err++; $display("FAIL j_pc: got %h want 0042", pc); end
        #2 rst_n = 0; #1;
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL async_reset_pc: got %h want 0000", pc); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL async_reset_empty: got %b want 1", ras_empty); end
        #1 rst_n = 1;
        tick(); n_cmp++; if (pc !== 16'h0001) begin n_err++; $display("FAIL rel1: got %h want 0001", pc); end
        tick(); n_cmp++; if (pc !== 16'h0002) begin n_err++; $display("FAIL rel2: got %h want 0002", pc); end
        tick(); n_cmp++; if (pc !== 16'h0003) begin n_err++; $display("FAIL rel3: got %h want 0003", pc); end
    endtask

    task automatic test_wrap();
        id_valid = 1; J = 1; jmp_target = 16'hFFFF;
        tick(); clr(); #1;
        n_cmp++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_load: got %h want ffff", pc); end
        n_cmp++; if (pcSrc !== 3'b000 || kill_if !== 1'b0) begin n_err++; $display("FAIL wrap_src: got %b/%b want 000/0", pcSrc, kill_if); end
        tick();
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
    endtask

    task automatic test_nest();
        id_valid = 1; CALL = 1; id_pc = 16'h0010; jmp_target = 16'h0100; #1;
        n_cmp++; if (pcSrc !== 3'b001 || kill_if !== 1'b1 || kill_id !== 1'b0) begin n_err++; $display("FAIL call_ctrl: got %b%b%b want 00110", pcSrc, kill_if, kill_id); end
        tick(); n_cmp++; if (pc !== 16'h0100) begin n_err++; $display("FAIL call1_pc: got %h want 0100", pc); end
        id_pc = 16'h0104; jmp_target = 16'h0200;
        tick(); n_cmp++; if (pc !== 16'h0200) begin n_err++; $display("FAIL call2_pc: got %h want 0200", pc); end
        n_cmp++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL nest_nonempty: got %b want 0", ras_empty); end
        CALL = 0; RET = 1; jr_target = 16'hBEEF; #1;
        n_cmp++; if (pcSrc !== 3'b011 || kill_if !== 1'b1 || ras_underflow !== 1'b0) begin n_err++; $display("FAIL ret_ctrl: got %b%b%b want 01110", pcSrc, kill_if, ras_underflow); end
        tick(); n_cmp++; if (pc !== 16'h0105) begin n_err++; $display("FAIL ret1_pc: got %h want 0105", pc); end
        tick(); n_cmp++; if (pc !== 16'h0011) begin n_err++; $display("FAIL ret2_pc: got %h want 0011", pc); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL nest_empty: got %b want 1", ras_empty); end
        clr();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0006; exp_ret[1] = 16'h0005; exp_ret[2] = 16'h0004; exp_ret[3] = 16'h0003;
        id_valid = 1; CALL = 1;
        for (int i = 1; i <= 5; i++) begin
            id_pc = 16'(i); jmp_target = 16'(16'h0400 + i);
            tick();
            if (i == 4) begin
                n_cmp++; if (ras_full !== 1'b1) begin n_err++; $display("FAIL ovf_full4: got %b want 1", ras_full); end
            end
        end
        n_cmp++; if (pc !== 16'h0405 || ras_full !== 1'b1) begin n_err++; $display("FAIL ovf_call5: got %h/%b want 0405/1", pc, ras_full); end
        CALL = 0; RET = 1; jr_target = 16'h0777;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (pc !== exp_ret[i]) begin n_err++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
        #1;
        n_cmp++; if (ras_underflow !== 1'b1 || pcSrc !== 3'b011) begin n_err++; $display("FAIL underflow_pulse: got %b/%b want 1/011", ras_underflow, pcSrc); end
        tick(); clr(); #1;
        n_cmp++; if (pc !== 16'h0777) begin n_err++; $display("FAIL underflow_pc: got %h want 0777", pc); end
        n_cmp++; if (ras_underflow !== 1'b0 || ras_empty !== 1'b1) begin n_err++; $display("FAIL underflow_after: got %b/%b want 0/1", ras_underflow, ras_empty); end
    endtask

    task automatic test_priority();
        id_valid = 1; CALL = 1; id_pc = 16'h0020; jmp_target = 16'h0500;
        tick(); n_cmp++; if (pc !== 16'h0500) begin n_err++; $display("FAIL prio_setup: got %h want 0500", pc); end
        id_pc = 16'h0030; jmp_target = 16'h0900; stall = 1;
        ex_br = 1; ex_taken = 1; ex_target = 16'h0080; #1;
        n_cmp++; if (pcSrc !== 3'b100 || kill_if !== 1'b1 || kill_id !== 1'b1) begin n_err++; $display("FAIL prio_ctrl: got %b%b%b want 10011", pcSrc, kill_if, kill_id); end
        tick(); clr();
        n_cmp++; if (pc !== 16'h0080) begin n_err++; $display("FAIL prio_pc: got %h want 0080", pc); end
        id_valid = 1; RET = 1; jr_target = 16'h0DDD;
        tick(); clr();
        n_cmp++; if (pc !== 16'h0021 || ras_empty !== 1'b1) begin n_err++; $display("FAIL prio_ras: got %h/%b want 0021/1", pc, ras_empty); end
        id_valid = 1; J = 1; jmp_target = 16'h0600; ex_br = 1; ex_taken = 0; ex_target = 16'h0AAA; #1;
        n_cmp++; if (pcSrc !== 3'b001 || kill_id !== 1'b0) begin n_err++; $display("FAIL nt_ctrl: got %b/%b want 001/0", pcSrc, kill_id); end
        tick(); clr();
        n_cmp++; if (pc !== 16'h0600) begin n_err++; $display("FAIL nt_pc: got %h want 0600", pc); end
        J = 1; jmp_target = 16'h0999; #1;
        n_cmp++; if (pcSrc !== 3'b000 || kill_if !== 1'b0) begin n_err++; $display("FAIL invalid_ctrl: got %b/%b want 000/0", pcSrc, kill_if); end
        tick(); clr();
        n_cmp++; if (pc !== 16'h0601) begin n_err++; $display("FAIL invalid_pc: got %h want 0601", pc); end
    endtask

    task automatic test_stall();
        stall = 1; id_valid = 1; J = 1; jmp_target = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (pcSrc !== 3'b101 || kill_if !== 1'b0 || kill_id !== 1'b0) begin n_err++; $display("FAIL stall_ctrl%0d: got %b%b%b want 10100", i, pcSrc, kill_if, kill_id); end
            tick();
            n_cmp++; if (pc !== 16'h0601) begin n_err++; $display("FAIL stall_hold%0d: got %h want 0601", i, pc); end
        end
        stall = 0; #1;
        n_cmp++; if (pcSrc !== 3'b001 || kill_if !== 1'b1) begin n_err++; $display("FAIL unstall_ctrl: got %b/%b want 001/1", pcSrc, kill_if); end
        tick(); clr();
        n_cmp++; if (pc !== 16'h0300) begin n_err++; $display("FAIL unstall_pc: got %h want 0300", pc); end
    endtask

    initial begin
        rst_n = 0;
        clr();
        test_reset();
        test_wrap();
        test_nest();
        test_overflow();
        test_priority();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
